// File: rtl/riscv_pkg.sv
// Shared core definitions: load/store size encodings (funct3) and LSU state type.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_DONE
  } lsu_state_t;

  // Illegal funct3 codes are reported through the same path as misalignment.
  function automatic logic lsu_bad_access(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      LDST_B, LDST_BU: bad = 1'b0;
      LDST_H, LDST_HU: bad = off[0];
      LDST_W:          bad = (off != 2'b00);
      default:         bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (we_i) begin
      case (size_i)
        LDST_B: begin
          be_o    = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        LDST_H: begin
          be_o    = 4'b0011 << {off_i[1], 1'b0};
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    case (off_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
    rhalf = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      LDST_B:  load_o = {{24{rbyte[7]}}, rbyte};
      LDST_BU: load_o = {24'd0, rbyte};
      LDST_H:  load_o = {{16{rhalf[15]}}, rhalf};
      LDST_HU: load_o = {16'd0, rhalf};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: one request/grant/response bus transaction per memory
// instruction, stalling the core until the DONE cycle.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_data_i,
  output logic [31:0]       lsu_data_o,
  output logic              lsu_stall_req_o,
  output logic              lsu_fault_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              fault;
  logic              accept;
  logic              idle;
  logic              al_we;
  logic [2:0]        al_size;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;

  assign idle   = (state_q == LSU_IDLE);
  assign fault  = lsu_req_i && lsu_bad_access(lsu_size_i, lsu_addr_i[1:0]);
  assign accept = idle && lsu_req_i && !fault;

  // One aligner serves both directions: live inputs format the store in IDLE,
  // latched fields steer the load extraction once the transaction is running.
  assign al_we   = idle ? lsu_we_i          : we_q;
  assign al_size = idle ? lsu_size_i        : size_q;
  assign al_off  = idle ? lsu_addr_i[1:0]   : off_q;

  riscv_lsu_align u_align (
    .we_i    (al_we),
    .size_i  (al_size),
    .off_i   (al_off),
    .wdata_i (lsu_data_i),
    .rdata_i (data_rdata_i),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .load_o  (al_load)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept)        state_d = LSU_REQ;
      LSU_REQ:  if (data_gnt_i)    state_d = LSU_RESP;
      LSU_RESP: if (data_rvalid_i) state_d = LSU_DONE;
      default:                     state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
        off_q   <= lsu_addr_i[1:0];
        addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
        be_q    <= al_be;
        wdata_q <= al_wdata;
      end
      if (state_q == LSU_RESP && data_rvalid_i && !we_q) begin
        rdata_q <= al_load;
      end
    end
  end

  assign lsu_data_o      = rdata_q;
  assign lsu_fault_o     = fault && idle;
  assign lsu_stall_req_o = lsu_req_i && !fault && (state_q != LSU_DONE);
  assign data_req_o      = (state_q == LSU_REQ);
  assign data_we_o       = we_q;
  assign data_be_o       = be_q;
  assign data_addr_o     = addr_q;
  assign data_wdata_o    = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: the driver queues expected transactions and a
// negedge monitor scores every bus request, completion and fault it observes.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_data_i = 32'd0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_fault_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'd0;

  typedef struct {
    bit          isFault;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] data;
    int          stall;
    int          reqCycles;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] lastData = 32'd0;

  riscv_lsu #(.ADDR_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_fault_o     (lsu_fault_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_gnt_i      (data_gnt_i),
    .data_rvalid_i   (data_rvalid_i),
    .data_rdata_i    (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one instruction, then plays the bus with the given grant/response delays.
  task automatic applyStimulus(input bit we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int gntDly, input int rvDly, input bit isFault,
                               input logic [3:0] expBe, input logic [31:0] expWdata,
                               input logic [31:0] expData);
    exp_t e;
    int   n;
    e.isFault   = isFault;
    e.addr      = addr & 32'hFFFF_FFFC;
    e.be        = expBe;
    e.we        = we;
    e.wdata     = expWdata;
    e.data      = we ? lastData : expData;
    e.stall     = 3 + gntDly + rvDly;
    e.reqCycles = gntDly + 1;
    if (!we && !isFault) lastData = expData;
    tick();
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wdata;
    expQ.push_back(e);
    if (isFault) begin
      tick();
      lsu_req_i = 1'b0;
      return;
    end
    tick();
    n = 0;
    while (!data_req_o && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) begin
      checkOutput("bus request timeout", {31'd0, data_req_o}, 32'd1);
      lsu_req_i = 1'b0;
      return;
    end
    for (int i = 0; i < gntDly; i++) tick();
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    for (int i = 0; i < rvDly; i++) tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    tick();
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'h5A5A_5A5A;
    tick();
    lsu_req_i = 1'b0;
  endtask

  // Monitor: captures the first bus-request cycle, counts stall/request cycles,
  // and scores the transaction when it completes (stall drops) or faults.
  initial begin
    logic [31:0] capAddr, capWdata;
    logic [3:0]  capBe;
    logic        capWe;
    bit          reqSeen;
    int          stallCnt, reqCnt;
    exp_t        e;
    reqSeen = 0; stallCnt = 0; reqCnt = 0;
    capAddr = 0; capWdata = 0; capBe = 0; capWe = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        reqSeen = 0; stallCnt = 0; reqCnt = 0;
      end else begin
        if (data_req_o) begin
          if (!reqSeen) begin
            capAddr = data_addr_o; capBe = data_be_o;
            capWe = data_we_o; capWdata = data_wdata_o;
          end
          reqSeen = 1;
          reqCnt++;
        end
        if (lsu_stall_req_o) stallCnt++;
        if (lsu_fault_o || (lsu_req_i && !lsu_stall_req_o)) begin
          checkOutput("scoreboard has entry", {31'd0, expQ.size() > 0}, 32'd1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("fault flag", {31'd0, lsu_fault_o}, {31'd0, e.isFault});
            if (e.isFault) begin
              checkOutput("fault stall", {31'd0, lsu_stall_req_o}, 32'd0);
              checkOutput("fault bus req", {31'd0, reqSeen}, 32'd0);
            end else begin
              checkOutput("bus addr", capAddr, e.addr);
              checkOutput("bus be", {28'd0, capBe}, {28'd0, e.be});
              checkOutput("bus we", {31'd0, capWe}, {31'd0, e.we});
              if (e.we) checkOutput("bus wdata", capWdata, e.wdata);
              checkOutput("req cycles", 32'(reqCnt), 32'(e.reqCycles));
              checkOutput("stall cycles", 32'(stallCnt), 32'(e.stall));
              checkOutput("load data", lsu_data_o, e.data);
            end
          end
          reqSeen = 0; stallCnt = 0; reqCnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tick();
    tick();
    @(negedge clk_i);
    checkOutput("reset lsu_data", lsu_data_o, 32'd0);
    checkOutput("reset addr", data_addr_o, 32'd0);
    checkOutput("reset wdata", data_wdata_o, 32'd0);
    checkOutput("reset be", {28'd0, data_be_o}, 32'd0);
    checkOutput("reset we/req", {30'd0, data_we_o, data_req_o}, 32'd0);
    checkOutput("reset fault/stall", {30'd0, lsu_fault_o, lsu_stall_req_o}, 32'd0);
    tick();
    rst_i = 1'b0;

    //             we  size     addr          wdata         rdata         g  r  flt be       expWdata      expData
    applyStimulus(0, 3'd0, 32'h0000_0103, 32'd0,        32'h80FF_1234, 0, 0, 0, 4'b1111, 32'd0,        32'hFFFF_FF80);
    applyStimulus(0, 3'd5, 32'h0000_0102, 32'd0,        32'h8001_0000, 0, 0, 0, 4'b1111, 32'd0,        32'h0000_8001);
    applyStimulus(0, 3'd1, 32'h0000_0102, 32'd0,        32'h8001_0000, 0, 0, 0, 4'b1111, 32'd0,        32'hFFFF_8001);
    applyStimulus(1, 3'd0, 32'h0000_0101, 32'h0000_00AB, 32'd0,        0, 0, 0, 4'b0010, 32'hABAB_ABAB, 32'd0);
    applyStimulus(1, 3'd1, 32'h0000_0102, 32'h0000_1234, 32'd0,        0, 0, 0, 4'b1100, 32'h1234_1234, 32'd0);
    applyStimulus(1, 3'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'd0,        2, 3, 0, 4'b1111, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(0, 3'd4, 32'h0000_0101, 32'd0,        32'h0000_9A00, 1, 0, 0, 4'b1111, 32'd0,        32'h0000_009A);
    applyStimulus(0, 3'd2, 32'h0000_0104, 32'd0,        32'h1234_5678, 0, 2, 0, 4'b1111, 32'd0,        32'h1234_5678);
    applyStimulus(0, 3'd0, 32'h0000_0100, 32'd0,        32'hFFFF_FF7F, 0, 0, 0, 4'b1111, 32'd0,        32'h0000_007F);
    applyStimulus(1, 3'd0, 32'h0000_0103, 32'h0000_0011, 32'd0,        0, 1, 0, 4'b1000, 32'h1111_1111, 32'd0);
    applyStimulus(0, 3'd2, 32'h0000_0102, 32'd0,        32'd0,         0, 0, 1, 4'b0000, 32'd0,        32'd0);
    applyStimulus(0, 3'd3, 32'h0000_0100, 32'd0,        32'd0,         0, 0, 1, 4'b0000, 32'd0,        32'd0);
    applyStimulus(1, 3'd1, 32'h0000_0101, 32'h0000_BEEF, 32'd0,        0, 0, 1, 4'b0000, 32'd0,        32'd0);
    applyStimulus(0, 3'd7, 32'h0000_0100, 32'd0,        32'd0,         0, 0, 1, 4'b0000, 32'd0,        32'd0);

    // Reset while waiting for the response, then a stray rvalid afterwards.
    tick();
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'd2;
    lsu_addr_i = 32'h0000_0300;
    tick();
    checkOutput("abort req asserted", {31'd0, data_req_o}, 32'd1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    rst_i      = 1'b1;
    lsu_req_i  = 1'b0;
    @(negedge clk_i);
    checkOutput("mid reset lsu_data", lsu_data_o, 32'd0);
    checkOutput("mid reset req", {31'd0, data_req_o}, 32'd0);
    checkOutput("mid reset stall", {31'd0, lsu_stall_req_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hFFFF_FFFF;
    tick();
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("late rvalid lsu_data", lsu_data_o, 32'd0);
    checkOutput("late rvalid req", {31'd0, data_req_o}, 32'd0);
    lastData = 32'd0;
    applyStimulus(0, 3'd2, 32'h0000_0304, 32'd0, 32'hCAFE_F00D, 1, 0, 0, 4'b1111, 32'd0, 32'hCAFE_F00D);

    tick();
    tick();
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load-store unit between the core's execute stage and the data-memory port. Consumes the decoder's memory control (`mem_req`, `mem_we`, `mem_size`) together with the ALU-computed address and the `rs2` store data. Runs a request/grant/response transaction on the data-memory bus, stalls the core for the duration, and returns sign- or zero-extended load data for write-back.

## Interface
- `ADDR_W`, 32: address width.
- `clk_i`  in  1  core clock; all state on rising edge.
- `rst_i`  in  1  asynchronous reset, active-high.
- `lsu_req_i`  in  1  memory instruction present; the core holds all `lsu_*_i` stable while `lsu_stall_req_o` is 1.
- `lsu_we_i`  in  1  1 = store, 0 = load.
- `lsu_size_i`  in  3  funct3 encoding: B=0, H=1, W=2, BU=4, HU=5.
- `lsu_addr_i`  in  ADDR_W  byte address.
- `lsu_data_i`  in  32  store data (`rs2`).
- `lsu_data_o`  out  32  extended load result, registered.
- `lsu_stall_req_o`  out  1  core stall request.
- `lsu_fault_o`  out  1  one-cycle pulse for a misaligned access or an illegal size.
- `data_req_o`  out  1  bus request.
- `data_we_o`  out  1  bus write enable.
- `data_be_o`  out  4  byte enables.
- `data_addr_o`  out  ADDR_W  word address, with `[1:0]` forced to 0.
- `data_wdata_o`  out  32  lane-replicated store data.
- `data_gnt_i`  in  1  bus accepted the request.
- `data_rvalid_i`  in  1  response valid; loads and stores both get one.
- `data_rdata_i`  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- **IDLE**
  - Fault check: a request is faulty if `lsu_size_i` is in {3, 6, 7}, or it is H/HU with `addr[0]`=1, or it is W with `addr[1:0]`≠0.
  - On `lsu_req_i` with a fault: `lsu_fault_o`=1 combinationally, `lsu_stall_req_o`=0, no bus activity, stay in IDLE.
  - On `lsu_req_i` with no fault: latch `we`, `size`, `addr[1:0]`, word address, byte enables and wdata into registers, then go to REQ.
- **REQ**: `data_req_o`=1 with the latched fields. When `data_gnt_i`=1, go to RESP. `data_req_o` stays 1 until granted.
- **RESP**: `data_req_o`=0. When `data_rvalid_i`=1:
  - load: register the extracted and extended data into `lsu_data_o`;
  - store: `lsu_data_o` is unchanged.
  - Then go to DONE.
- **DONE**: unconditionally return to IDLE. A new request is accepted only from IDLE.
- `lsu_stall_req_o` = `lsu_req_i` AND no fault AND state ≠ DONE. The stall therefore drops in exactly one cycle, DONE, and the core advances on that edge.
- Store formatting:
  - B: `be` = 0001 << `addr[1:0]`; wdata = {4{`data[7:0]`}}.
  - H: `be` = 0011 << {`addr[1]`, 0}; wdata = {2{`data[15:0]`}}.
  - W: `be` = 1111; wdata = `data`.
- Loads use `be` = 1111. The lane is selected by the latched `addr[1:0]`:
  - B and H are sign-extended from the selected byte or half;
  - BU and HU are zero-extended;
  - W passes the word through unchanged.
- `data_rvalid_i` outside RESP and `data_gnt_i` outside REQ are ignored.

## Timing
- Reset values:
  - state = IDLE;
  - `lsu_data_o`, `data_addr_o`, `data_wdata_o` = 0;
  - `data_be_o` = 0;
  - `data_we_o` = 0, `data_req_o` = 0;
  - `lsu_fault_o` = 0, `lsu_stall_req_o` = 0 (the latter while `lsu_req_i` is low).
- Minimum latency, with `gnt` in the first REQ cycle and `rvalid` in the first RESP cycle:
  - request seen in IDLE at cycle 0;
  - REQ at cycle 1, RESP at cycle 2, DONE at cycle 3;
  - the stall is high during cycles 0–2 and `lsu_data_o` is valid from cycle 3.
- Each cycle of `gnt` or `rvalid` delay adds one stall cycle.
- Reset asserted mid-transaction returns the block to IDLE immediately and clears `data_req_o`. A response that arrives later is dropped.
- `gnt` and `rvalid` are never treated as arriving together. `rvalid` is only sampled from the cycle after the grant.

## Structure
- Shared package `riscv_pkg` holds:
  - the `LDST_B`/`H`/`W`/`BU`/`HU` constants, as already used by the decoder;
  - the `lsu_state_t` enum.
- Sub-module `riscv_lsu_align` is combinational. It takes size and offset and produces the store `be`/wdata and the load extraction and extension. It is unit-testable on its own.
- The FSM and registers live in `riscv_lsu`.

## Test plan
- Load LB at addr 0x103, rdata 0x80FF_1234, 0-wait bus: `be`=1111, `addr`=0x100. Stall high for 3 cycles, then `lsu_data_o`=0xFFFF_FF80.
- LHU at 0x102, rdata 0x8001_0000: `lsu_data_o`=0x0000_8001. LH at the same address and data gives 0xFFFF_8001.
- SB at 0x101 with data 0x0000_00AB: `be`=0010, wdata=0xABAB_ABAB, `we`=1. SH at 0x102 with data 0x1234: `be`=1100, wdata=0x1234_1234.
- SW with `gnt` delayed 2 cycles and `rvalid` delayed 3 cycles: `data_req_o` is held for 3 cycles, and the stall is high for 1+3+4=8 cycles before DONE.
- Faults: LW at 0x102 and size 3 at 0x100 each give a 1-cycle `lsu_fault_o`, stall 0, and `data_req_o` never asserted.
- Reset asserted while in RESP: state returns to IDLE and `lsu_data_o`=0. A late `rvalid` has no effect, and the next LW completes normally.
